// File: rtl/alu_share_arb.sv
// Round-robin sequencer sharing one registered ADD/SUB/SLT/SLTU ALU between NREQ requesters.
// One transaction at a time: accept in IDLE, compute in EXEC, hold the response in RESP until taken.
module alu_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [W*NREQ-1:0]   req_a,
  input  logic [W*NREQ-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [W-1:0]        rsp_data,
  output logic                rsp_ovf,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SLT  = 2'b10;

  state_t           r_state;
  logic [IDW-1:0]   r_last_grant;
  logic [IDW-1:0]   r_id;
  logic [1:0]       r_op;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_rsp_data;
  logic             r_rsp_ovf;
  logic             r_rsp_valid;
  logic             r_busy;

  logic             w_any;
  logic [IDW-1:0]   w_grant;
  logic [IDW-1:0]   w_idx;
  logic [NREQ-1:0]  w_req_ready;
  logic [W-1:0]     w_sum;
  logic [W-1:0]     w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_slt;
  logic             w_sltu;
  logic [W-1:0]     w_alu_data;
  logic             w_alu_ovf;

  // Scan upward from the requester after the last one served, wrapping at NREQ.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(r_last_grant) + k) % NREQ);
      if (!w_any && req_valid[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // NOTE: req_ready is combinational, so it is masked by rst_n to read 0 while reset is held.
  always_comb begin
    w_req_ready = '0;
    if (rst_n && (r_state == S_IDLE) && w_any) begin
      w_req_ready[w_grant] = 1'b1;
    end
  end

  assign w_sum     = r_a + r_b;
  assign w_diff    = r_a - r_b;
  assign w_add_ovf = (r_a[W-1] == r_b[W-1]) && (w_sum[W-1]  != r_a[W-1]);
  assign w_sub_ovf = (r_a[W-1] != r_b[W-1]) && (w_diff[W-1] != r_a[W-1]);
  // Signed less-than stays correct when the subtraction overflows.
  assign w_slt     = w_diff[W-1] ^ w_sub_ovf;
  assign w_sltu    = (r_a < r_b);

  always_comb begin
    w_alu_data = '0;
    w_alu_ovf  = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_alu_data = w_sum;
        w_alu_ovf  = w_add_ovf;
      end
      OP_SUB: begin
        w_alu_data = w_diff;
        w_alu_ovf  = w_sub_ovf;
      end
      OP_SLT:  w_alu_data = {{(W-1){1'b0}}, w_slt};
      default: w_alu_data = {{(W-1){1'b0}}, w_sltu};
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= IDW'(NREQ - 1);
      r_id         <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_data   <= '0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_grant;
            r_op    <= req_op[2*w_grant +: 2];
            r_a     <= req_a[W*w_grant +: W];
            r_b     <= req_b[W*w_grant +: W];
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data  <= w_alu_data;
          r_rsp_ovf   <= w_alu_ovf;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          // Fairness pointer advances only once the result has actually been consumed.
          if (rsp_ready) begin
            r_last_grant <= r_id;
            r_rsp_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_ovf   = r_rsp_ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed corner cases plus randomized traffic, checked against a
// behavioural model using wide signed arithmetic and a plain round-robin scan over a pending table.
module tb_alu_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] SLT  = 2'b10;
  localparam logic [1:0] SLTU = 2'b11;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [2*NREQ-1:0]   req_op;
  logic [W*NREQ-1:0]   req_a;
  logic [W*NREQ-1:0]   req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_data;
  logic                rsp_ovf;
  logic                busy;

  alu_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: pending request table and the id of the last completed requester.
  bit          m_valid [NREQ];
  logic [1:0]  m_op    [NREQ];
  logic [31:0] m_a     [NREQ];
  logic [31:0] m_b     [NREQ];
  int          m_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    m_valid[i] = 1'b1;
    m_op[i]    = op;
    m_a[i]     = a;
    m_b[i]     = b;
    req_valid[i]       = 1'b1;
    req_op[2*i +: 2]   = op;
    req_a[W*i +: W]    = a;
    req_b[W*i +: W]    = b;
  endtask

  task automatic clr_req(input int i);
    m_valid[i]       = 1'b0;
    req_valid[i]     = 1'b0;
    req_op[2*i +: 2] = 2'b00;
    req_a[W*i +: W]  = '0;
    req_b[W*i +: W]  = '0;
  endtask

  function automatic int exp_grant();
    for (int k = 1; k <= NREQ; k++) begin
      if (m_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Result computed on 64-bit signed integers: overflow means the true result leaves the 32-bit range.
  task automatic ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output logic o);
    longint sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r  = 0;
    d  = '0;
    o  = 1'b0;
    case (op)
      ADD: begin
        r = sa + sb;
        d = r[31:0];
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      SUB: begin
        r = sa - sb;
        d = r[31:0];
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      SLT:     d = (sa < sb) ? 32'd1 : 32'd0;
      default: d = (a < b) ? 32'd1 : 32'd0;
    endcase
  endtask

  // One full transaction, entered just after a rising edge while the DUT is in IDLE.
  task automatic run_txn(input int hold, input bit refill, input int expect_g);
    int              g;
    logic [NREQ-1:0] exp_rdy;
    logic [1:0]      op;
    logic [31:0]     a, b, d;
    logic            o;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_rsp_valid", rsp_valid, 0);
    g = exp_grant();
    if (g < 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL no_pending_request: observed none expected at least one");
      return;
    end
    exp_rdy    = '0;
    exp_rdy[g] = 1'b1;
    check("req_ready_grant", req_ready, exp_rdy);
    if (expect_g >= 0) begin
      exp_rdy           = '0;
      exp_rdy[expect_g] = 1'b1;
      check($sformatf("grant_order_%0d", expect_g), req_ready, exp_rdy);
    end
    op = m_op[g];
    a  = m_a[g];
    b  = m_b[g];
    ref_alu(op, a, b, d, o);
    @(posedge clk); #1;
    if (refill) set_req(g, 2'($urandom_range(0, 3)), rand_operand(), rand_operand());
    else        clr_req(g);
    rsp_ready = (hold == 0);
    @(negedge clk);
    check("exec_busy", busy, 1);
    check("exec_rsp_valid", rsp_valid, 0);
    check("exec_req_ready", req_ready, 0);
    @(posedge clk); #1;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_id", rsp_id, g);
      check("hold_rsp_data", rsp_data, d);
      check("hold_rsp_ovf", rsp_ovf, o);
      check("hold_req_ready", req_ready, 0);
      check("hold_busy", busy, 1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, g);
    check($sformatf("rsp_data_op%0d", op), rsp_data, d);
    check($sformatf("rsp_ovf_op%0d", op), rsp_ovf, o);
    @(posedge clk); #1;
    m_last = g;
  endtask

  // At most one accept strobe may be high at any sample point.
  always @(negedge clk) begin
    if (rst_n === 1'b1) check("ready_onehot0", $onehot0(req_ready), 1);
  end

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    m_last    = NREQ - 1;
    for (int i = 0; i < NREQ; i++) m_valid[i] = 1'b0;
    #2 rst_n = 1'b0;

    // Reset state, with a request pending to show req_ready stays low during reset.
    set_req(0, ADD, 32'd1, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_ovf", rsp_ovf, 0);
    clr_req(0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single SLT from requester 1.
    set_req(1, SLT, 32'hFFFF_FFFE, 32'd1);
    run_txn(0, 0, 1);

    // Comparisons whose subtraction overflows.
    set_req(2, SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    run_txn(0, 0, 2);
    set_req(3, SLT, 32'h8000_0000, 32'd1);
    run_txn(0, 0, 3);
    set_req(0, SLTU, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    run_txn(0, 0, 0);

    // Add/sub overflow and a plain subtraction.
    set_req(1, ADD, 32'h7FFF_FFFF, 32'd1);
    run_txn(0, 0, 1);
    set_req(2, SUB, 32'h8000_0000, 32'd1);
    run_txn(0, 0, 2);
    set_req(3, SUB, 32'd5, 32'd3);
    run_txn(0, 0, 3);

    // All four requesters continuously valid: grants rotate 0,1,2,3,0,...
    for (int i = 0; i < NREQ; i++) set_req(i, 2'($urandom_range(0, 3)), rand_operand(), rand_operand());
    for (int t = 0; t < 2 * NREQ; t++) run_txn(0, 1, t % NREQ);

    // Backpressure for 10 cycles in RESP.
    run_txn(10, 1, 0);

    // Reset while an operation sits in EXEC.
    for (int i = 0; i < NREQ; i++) clr_req(i);
    set_req(2, ADD, 32'h1234_0000, 32'h0000_5678);
    @(negedge clk);
    check("pre_rst_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    check("pre_rst_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", req_ready, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rsp_id", rsp_id, 0);
    check("midrst_rsp_data", rsp_data, 0);
    check("midrst_rsp_ovf", rsp_ovf, 0);
    m_last = NREQ - 1;
    set_req(0, SUB, 32'd10, 32'd3);
    repeat (2) begin
      @(negedge clk);
      check("inrst_rsp_valid", rsp_valid, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn(0, 0, 0);
    run_txn(0, 0, 2);

    // Randomized traffic with random backpressure and refill.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!m_valid[i] && ($urandom_range(0, 2) == 0))
          set_req(i, 2'($urandom_range(0, 3)), rand_operand(), rand_operand());
      end
      if (exp_grant() < 0) set_req($urandom_range(0, NREQ - 1), 2'($urandom_range(0, 3)), rand_operand(), rand_operand());
      run_txn($urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
    end

    @(negedge clk);
    check("final_idle_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
